// File: rtl/ex_pkg.sv
// ex_pkg: shared type-bit indices, branch-kind bit order and dispatch control payloads.
package ex_pkg;
  localparam int INS_ALU   = 0;
  localparam int INS_JAL   = 1;
  localparam int INS_JALR  = 2;
  localparam int INS_LUI   = 3;
  localparam int INS_AUIPC = 4;
  localparam int KIND_JAL   = 0;
  localparam int KIND_JALR  = 1;
  localparam int KIND_LUI   = 2;
  localparam int KIND_AUIPC = 3;
  typedef struct packed {
    logic [3:0] opc;
  } alu_ctl_t;
  typedef struct packed {
    logic [3:0] kind;
    logic [2:0] cond;
  } bnch_ctl_t;
  function automatic logic [3:0] kind_of(input logic [4:0] typ);
    return {typ[INS_AUIPC], typ[INS_LUI], typ[INS_JALR], typ[INS_JAL]};
  endfunction
endpackage

// File: rtl/ex_operand_bypass.sv
// ex_operand_bypass: one source operand (tag 0 -> zero, lowest matching bypass port, else RF).
// Forwarding only when EX_DISPATCH_BYPASS_EN is defined; otherwise bypass inputs are ignored.
module ex_operand_bypass #(
  parameter int XLEN  = 32,
  parameter int PRF_W = 6,
  parameter int PORTS = 2
) (
  input  logic [PRF_W-1:0]       tag_i,
  input  logic [XLEN-1:0]        rf_i,
  input  logic [PORTS-1:0]       byp_valid_i,
  input  logic [PORTS*PRF_W-1:0] byp_dest_i,
  input  logic [PORTS*XLEN-1:0]  byp_data_i,
  output logic [XLEN-1:0]        op_o
);
`ifdef EX_DISPATCH_BYPASS_EN
  always_comb begin
    op_o = rf_i;
    for (int p = PORTS-1; p >= 0; p--)
      if (byp_valid_i[p] && byp_dest_i[p*PRF_W +: PRF_W] == tag_i) op_o = byp_data_i[p*XLEN +: XLEN];
    if (tag_i == '0) op_o = '0;
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_valid_i, byp_dest_i, byp_data_i};
  assign op_o = (tag_i == '0) ? '0 : rf_i;
`endif
endmodule

// File: rtl/ex_dispatch.sv
// ex_dispatch: register-read and dispatch stage feeding ALU and branch unit, with dest wakeup.
// Define EX_DISPATCH_BYPASS_EN to enable writeback forwarding onto the operands.
module ex_dispatch import ex_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int PRF_W        = 6,
  parameter int ROB_W        = 6,
  parameter int BYPASS_PORTS = 2,
  parameter int PRED_W       = 4
) (
  input  logic                          cpu_clock_i,
  input  logic                          cpu_resetn_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ROB_W-1:0]              in_rob_i,
  input  logic [PRF_W-1:0]              in_dest_i,
  input  logic [3:0]                    in_opcode_i,
  input  logic [4:0]                    in_type_i,
  input  logic                          in_imm_vld_i,
  input  logic [XLEN-1:0]               in_imm_i,
  input  logic [XLEN-1:0]               in_pc_i,
  input  logic [PRED_W-1:0]             in_pred_i,
  input  logic [PRF_W-1:0]              in_rs1_i,
  input  logic [PRF_W-1:0]              in_rs2_i,
  output logic [PRF_W-1:0]              rs1_o,
  output logic [PRF_W-1:0]              rs2_o,
  input  logic [XLEN-1:0]               rs1_data_i,
  input  logic [XLEN-1:0]               rs2_data_i,
  input  logic [BYPASS_PORTS-1:0]       byp_valid_i,
  input  logic [BYPASS_PORTS*PRF_W-1:0] byp_dest_i,
  input  logic [BYPASS_PORTS*XLEN-1:0]  byp_data_i,
  output logic                          alu_valid_o,
  input  logic                          alu_ready_i,
  output logic [XLEN-1:0]               alu_a_o,
  output logic [XLEN-1:0]               alu_b_o,
  output logic [3:0]                    alu_opc_o,
  output logic [ROB_W-1:0]              alu_rob_o,
  output logic [PRF_W-1:0]              alu_dest_o,
  output logic                          bnch_valid_o,
  input  logic                          bnch_ready_i,
  output logic [XLEN-1:0]               bnch_op1_o,
  output logic [XLEN-1:0]               bnch_op2_o,
  output logic [XLEN-1:0]               bnch_offset_o,
  output logic [XLEN-1:0]               bnch_pc_o,
  output logic [3:0]                    bnch_kind_o,
  output logic [2:0]                    bnch_cond_o,
  output logic [ROB_W-1:0]              bnch_rob_o,
  output logic [PRF_W-1:0]              bnch_dest_o,
  output logic [PRED_W-1:0]             bnch_pred_o,
  output logic                          wakeup_valid_o,
  output logic [PRF_W-1:0]              wakeup_dest_o
);
  logic [XLEN-1:0] op1, op2;
  logic accept, alu_bound, bnch_bound;
  logic alu_valid_d, alu_valid_q, bnch_valid_d, bnch_valid_q, wake_d, wake_q;
  logic [XLEN-1:0] alu_a_q, alu_b_q, bnch_op1_q, bnch_op2_q, bnch_off_q, bnch_pc_q;
  logic [ROB_W-1:0] alu_rob_q, bnch_rob_q;
  logic [PRF_W-1:0] alu_dest_q, bnch_dest_q, wake_dest_q;
  logic [PRED_W-1:0] bnch_pred_q;
  alu_ctl_t alu_ctl_q;
  bnch_ctl_t bnch_ctl_q;
  ex_operand_bypass #(.XLEN(XLEN), .PRF_W(PRF_W), .PORTS(BYPASS_PORTS)) u_rs1 (
    .tag_i(in_rs1_i), .rf_i(rs1_data_i), .byp_valid_i(byp_valid_i),
    .byp_dest_i(byp_dest_i), .byp_data_i(byp_data_i), .op_o(op1));
  ex_operand_bypass #(.XLEN(XLEN), .PRF_W(PRF_W), .PORTS(BYPASS_PORTS)) u_rs2 (
    .tag_i(in_rs2_i), .rf_i(rs2_data_i), .byp_valid_i(byp_valid_i),
    .byp_dest_i(byp_dest_i), .byp_data_i(byp_data_i), .op_o(op2));
  assign rs1_o      = in_rs1_i;
  assign rs2_o      = in_rs2_i;
  assign in_ready_o = (!alu_valid_q || alu_ready_i) && (!bnch_valid_q || bnch_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign alu_bound  = in_type_i[INS_ALU];
  assign bnch_bound = |in_type_i[INS_AUIPC:INS_JAL] || !in_type_i[INS_ALU];
  // An accept implies both slots are empty or draining, so an unbound slot simply clears.
  always_comb begin
    alu_valid_d  = !flush_i && (accept ? alu_bound : alu_valid_q && !alu_ready_i);
    bnch_valid_d = !flush_i && (accept ? bnch_bound : bnch_valid_q && !bnch_ready_i);
    wake_d       = accept && |in_type_i && in_dest_i != '0;
  end
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      alu_valid_q  <= 1'b0;
      bnch_valid_q <= 1'b0;
      wake_q       <= 1'b0;
    end else begin
      alu_valid_q  <= alu_valid_d;
      bnch_valid_q <= bnch_valid_d;
      wake_q       <= wake_d;
    end
  end
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      {alu_a_q, alu_b_q, alu_ctl_q, alu_rob_q, alu_dest_q} <= '0;
      {bnch_op1_q, bnch_op2_q, bnch_off_q, bnch_pc_q, bnch_ctl_q} <= '0;
      {bnch_rob_q, bnch_dest_q, bnch_pred_q, wake_dest_q} <= '0;
    end else if (accept) begin
      wake_dest_q <= in_dest_i;
      if (alu_bound) begin
        alu_a_q       <= op1;
        alu_b_q       <= in_imm_vld_i ? in_imm_i : op2;
        alu_ctl_q.opc <= in_opcode_i;
        alu_rob_q     <= in_rob_i;
        alu_dest_q    <= in_dest_i;
      end
      if (bnch_bound) begin
        bnch_op1_q      <= op1;
        bnch_op2_q      <= op2;
        bnch_off_q      <= in_imm_i;
        bnch_pc_q       <= in_pc_i;
        bnch_ctl_q.kind <= kind_of(in_type_i);
        bnch_ctl_q.cond <= in_opcode_i[2:0];
        bnch_rob_q      <= in_rob_i;
        bnch_dest_q     <= in_dest_i;
        bnch_pred_q     <= in_pred_i;
      end
    end
  end
  assign alu_valid_o    = alu_valid_q;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_opc_o      = alu_ctl_q.opc;
  assign alu_rob_o      = alu_rob_q;
  assign alu_dest_o     = alu_dest_q;
  assign bnch_valid_o   = bnch_valid_q;
  assign bnch_op1_o     = bnch_op1_q;
  assign bnch_op2_o     = bnch_op2_q;
  assign bnch_offset_o  = bnch_off_q;
  assign bnch_pc_o      = bnch_pc_q;
  assign bnch_kind_o    = bnch_ctl_q.kind;
  assign bnch_cond_o    = bnch_ctl_q.cond;
  assign bnch_rob_o     = bnch_rob_q;
  assign bnch_dest_o    = bnch_dest_q;
  assign bnch_pred_o    = bnch_pred_q;
  assign wakeup_valid_o = wake_q;
  assign wakeup_dest_o  = wake_dest_q;
endmodule

// File: tb/tb_ex_dispatch.sv
// tb_ex_dispatch: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ex_dispatch;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  logic flush_i, in_valid_i, in_ready_o, in_imm_vld_i;
  logic [5:0] in_rob_i, in_dest_i, in_rs1_i, in_rs2_i, rs1_o, rs2_o;
  logic [3:0] in_opcode_i, in_pred_i;
  logic [4:0] in_type_i;
  logic [31:0] in_imm_i, in_pc_i, rs1_data_i, rs2_data_i;
  logic [1:0] byp_valid_i;
  logic [5:0] bd [2];
  logic [31:0] bdat [2];
  logic [11:0] byp_dest_i;
  logic [63:0] byp_data_i;
  logic alu_valid_o, alu_ready_i, bnch_valid_o, bnch_ready_i, wakeup_valid_o;
  logic [31:0] alu_a_o, alu_b_o, bnch_op1_o, bnch_op2_o, bnch_offset_o, bnch_pc_o;
  logic [3:0] alu_opc_o, bnch_kind_o, bnch_pred_o;
  logic [2:0] bnch_cond_o;
  logic [5:0] alu_rob_o, alu_dest_o, bnch_rob_o, bnch_dest_o, wakeup_dest_o;
  int n_tests = 0;
  int n_fail = 0;
  assign byp_dest_i = {bd[1], bd[0]};
  assign byp_data_i = {bdat[1], bdat[0]};

  ex_dispatch dut (
    .cpu_clock_i(clk), .cpu_resetn_i(resetn), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rob_i(in_rob_i),
    .in_dest_i(in_dest_i), .in_opcode_i(in_opcode_i), .in_type_i(in_type_i),
    .in_imm_vld_i(in_imm_vld_i), .in_imm_i(in_imm_i), .in_pc_i(in_pc_i),
    .in_pred_i(in_pred_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .byp_valid_i(byp_valid_i), .byp_dest_i(byp_dest_i), .byp_data_i(byp_data_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o), .alu_opc_o(alu_opc_o), .alu_rob_o(alu_rob_o),
    .alu_dest_o(alu_dest_o), .bnch_valid_o(bnch_valid_o), .bnch_ready_i(bnch_ready_i),
    .bnch_op1_o(bnch_op1_o), .bnch_op2_o(bnch_op2_o), .bnch_offset_o(bnch_offset_o),
    .bnch_pc_o(bnch_pc_o), .bnch_kind_o(bnch_kind_o), .bnch_cond_o(bnch_cond_o),
    .bnch_rob_o(bnch_rob_o), .bnch_dest_o(bnch_dest_o), .bnch_pred_o(bnch_pred_o),
    .wakeup_valid_o(wakeup_valid_o), .wakeup_dest_o(wakeup_dest_o));

  // Reference operand: zero tag, first matching live forwarding port, else register file.
  function automatic logic [31:0] ref_op(input logic [5:0] tag, input logic [31:0] rf);
    if (tag == 6'd0) return 32'd0;
`ifdef EX_DISPATCH_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (byp_valid_i[p] && bd[p] == tag) return bdat[p];
`endif
    return rf;
  endfunction

  task automatic set_uop(input logic [4:0] typ, input logic [5:0] rs1, input logic [5:0] rs2,
                         input logic [31:0] rf1, input logic [31:0] rf2, input logic [5:0] dest);
    in_valid_i = 1'b1; in_type_i = typ; in_rs1_i = rs1; in_rs2_i = rs2;
    rs1_data_i = rf1; rs2_data_i = rf2; in_dest_i = dest;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid_i = 1'b0; flush_i = 1'b0; alu_ready_i = 1'b1; bnch_ready_i = 1'b1; byp_valid_i = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    flush_i = 0; in_valid_i = 0; in_rob_i = 0; in_dest_i = 0; in_opcode_i = 0; in_type_i = 0;
    in_imm_vld_i = 0; in_imm_i = 0; in_pc_i = 0; in_pred_i = 0; in_rs1_i = 0; in_rs2_i = 0;
    rs1_data_i = 0; rs2_data_i = 0; byp_valid_i = 0; bd[0] = 0; bd[1] = 0; bdat[0] = 0; bdat[1] = 0;
    alu_ready_i = 1; bnch_ready_i = 1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1; #1;
    n_tests++;
    if ({alu_valid_o, bnch_valid_o, wakeup_valid_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids got %b want 000", {alu_valid_o, bnch_valid_o, wakeup_valid_o});
    end
    n_tests++;
    if ({alu_a_o, alu_b_o, bnch_pc_o, bnch_op1_o, wakeup_dest_o} !== '0) begin
      n_fail++; $display("FAIL reset_payload got %h want 0", {alu_a_o, alu_b_o, bnch_pc_o, bnch_op1_o, wakeup_dest_o});
    end
    n_tests++;
    if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
  endtask

  task automatic test_alu_add();
    @(negedge clk);
    set_uop(5'b00001, 6'd3, 6'd4, 32'h10, 32'h20, 6'd9); in_opcode_i = 4'h2; in_imm_vld_i = 0;
    #1;
    n_tests++;
    if ({in_ready_o, rs1_o, rs2_o} !== {1'b1, 6'd3, 6'd4}) begin
      n_fail++; $display("FAIL alu_req got %b/%0d/%0d want 1/3/4", in_ready_o, rs1_o, rs2_o);
    end
    @(posedge clk); #1;
    set_uop(5'b00001, 6'd0, 6'd4, 32'h55, 32'h20, 6'd0); in_imm_vld_i = 1; in_imm_i = 32'h1234;
    n_tests++;
    if ({alu_valid_o, alu_a_o, alu_b_o, alu_opc_o, alu_dest_o, bnch_valid_o} !== {1'b1, 32'h10, 32'h20, 4'h2, 6'd9, 1'b0}) begin
      n_fail++; $display("FAIL alu_add got v%b a%h b%h op%h d%0d bv%b", alu_valid_o, alu_a_o, alu_b_o, alu_opc_o, alu_dest_o, bnch_valid_o);
    end
    n_tests++;
    if ({wakeup_valid_o, wakeup_dest_o} !== {1'b1, 6'd9}) begin
      n_fail++; $display("FAIL alu_wakeup got %b/%0d want 1/9", wakeup_valid_o, wakeup_dest_o);
    end
    @(posedge clk); #1;
    in_valid_i = 0; in_imm_vld_i = 0;
    n_tests++;
    if ({alu_valid_o, alu_a_o, alu_b_o, wakeup_valid_o} !== {1'b1, 32'h0, 32'h1234, 1'b0}) begin
      n_fail++; $display("FAIL alu_imm_zero got v%b a%h b%h w%b want 1/0/1234/0", alu_valid_o, alu_a_o, alu_b_o, wakeup_valid_o);
    end
    idle();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_a, exp_b;
`ifdef EX_DISPATCH_BYPASS_EN
    exp_a = 32'hAA; exp_b = 32'hCC;
`else
    exp_a = 32'h11; exp_b = 32'h22;
`endif
    @(negedge clk);
    set_uop(5'b00001, 6'd5, 6'd6, 32'h11, 32'h22, 6'd7); in_imm_vld_i = 0;
    byp_valid_i = 2'b11; bd[0] = 6'd5; bdat[0] = 32'hAA; bd[1] = 6'd6; bdat[1] = 32'hCC;
    @(posedge clk); #1;
    in_valid_i = 0; bd[1] = 6'd5; bdat[1] = 32'hBB;
    n_tests++;
    if ({alu_a_o, alu_b_o} !== {exp_a, exp_b}) begin
      n_fail++; $display("FAIL bypass got a%h b%h want a%h b%h", alu_a_o, alu_b_o, exp_a, exp_b);
    end
    // both ports now carry p5; the lower port must win
    @(negedge clk);
    set_uop(5'b00001, 6'd5, 6'd0, 32'h11, 32'h22, 6'd7); bd[0] = 6'd5;
    @(posedge clk); #1;
    in_valid_i = 0;
    n_tests++;
    if ({alu_a_o, alu_b_o} !== {exp_a, 32'h0}) begin
      n_fail++; $display("FAIL bypass_prio got a%h b%h want a%h b0", alu_a_o, alu_b_o, exp_a);
    end
    idle();
  endtask

  task automatic test_jal_stall();
    @(negedge clk);
    set_uop(5'b00011, 6'd2, 6'd3, 32'hA0, 32'hB0, 6'd12);
    in_pc_i = 32'h1000; in_imm_i = 32'h40; in_pred_i = 4'hA; in_rob_i = 6'd33; in_opcode_i = 4'h3;
    alu_ready_i = 1; bnch_ready_i = 0;
    @(posedge clk); #1;
    in_valid_i = 0; in_pc_i = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({alu_valid_o, bnch_valid_o, in_ready_o} !== {i == 0, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL jal_stall%0d got a%b b%b r%b want a%b b1 r0", i, alu_valid_o, bnch_valid_o, in_ready_o, i == 0);
      end
      n_tests++;
      if ({bnch_pc_o, bnch_offset_o, bnch_op1_o, bnch_kind_o, bnch_rob_o, bnch_pred_o} !== {32'h1000, 32'h40, 32'hA0, 4'b0001, 6'd33, 4'hA}) begin
        n_fail++; $display("FAIL jal_payload%0d got pc%h off%h op1%h k%b rob%0d pr%h", i, bnch_pc_o, bnch_offset_o, bnch_op1_o, bnch_kind_o, bnch_rob_o, bnch_pred_o);
      end
      @(posedge clk); #1;
    end
    bnch_ready_i = 1; #1;
    n_tests++;
    if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL jal_release_ready got %b want 1", in_ready_o); end
    @(posedge clk); #1;
    n_tests++;
    if (bnch_valid_o !== 1'b0) begin n_fail++; $display("FAIL jal_drain got %b want 0", bnch_valid_o); end
  endtask

  task automatic test_cond_branch();
    @(negedge clk);
    set_uop(5'b00000, 6'd1, 6'd2, 32'h5, 32'h6, 6'd0); in_opcode_i = 4'b1101;
    @(posedge clk); #1;
    in_valid_i = 0;
    n_tests++;
    if ({bnch_valid_o, alu_valid_o, wakeup_valid_o, bnch_cond_o, bnch_kind_o, bnch_op2_o} !== {3'b100, 3'b101, 4'b0000, 32'h6}) begin
      n_fail++; $display("FAIL cond_branch got b%b a%b w%b c%b k%b op2 %h", bnch_valid_o, alu_valid_o, wakeup_valid_o, bnch_cond_o, bnch_kind_o, bnch_op2_o);
    end
    idle();
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_uop(5'b00001, 6'd1, 6'd2, 32'h1, 32'h2, 6'd4); alu_ready_i = 0;
    @(posedge clk); #1;
    set_uop(5'b00011, 6'd1, 6'd2, 32'h1, 32'h2, 6'd5); flush_i = 1; #1;
    n_tests++;
    if ({alu_valid_o, in_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL flush_pre got v%b r%b want 1/0", alu_valid_o, in_ready_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({alu_valid_o, bnch_valid_o, wakeup_valid_o} !== 3'b000) begin
      n_fail++; $display("FAIL flush_stalled got %b want 000", {alu_valid_o, bnch_valid_o, wakeup_valid_o});
    end
    alu_ready_i = 1;
    @(posedge clk); #1;
    flush_i = 0; in_valid_i = 0;
    n_tests++;
    if ({alu_valid_o, bnch_valid_o, wakeup_valid_o} !== 3'b000) begin
      n_fail++; $display("FAIL flush_accept got %b want 000", {alu_valid_o, bnch_valid_o, wakeup_valid_o});
    end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_uop(5'b00011, 6'd1, 6'd2, 32'h77, 32'h2, 6'd8);
    @(posedge clk); #1;
    in_valid_i = 0;
    n_tests++;
    if ({alu_valid_o, bnch_valid_o, wakeup_valid_o} !== 3'b111) begin
      n_fail++; $display("FAIL areset_pre got %b want 111", {alu_valid_o, bnch_valid_o, wakeup_valid_o});
    end
    #1 resetn = 1'b0;
    #1;
    n_tests++;
    if ({alu_valid_o, bnch_valid_o, wakeup_valid_o, alu_a_o} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL areset got %b a%h want 000 a0", {alu_valid_o, bnch_valid_o, wakeup_valid_o}, alu_a_o);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] types [7] = '{5'b00001, 5'b00011, 5'b00101, 5'b01000, 5'b10000, 5'b00000, 5'b01001};
    logic m_av, m_bv, m_wv, acc, exp_rdy;
    logic [31:0] m_a, m_b, m_o1, m_o2, m_off, m_pc;
    logic [3:0] m_opc, m_kind, m_pred;
    logic [2:0] m_cond;
    logic [5:0] m_arob, m_adest, m_brob, m_bdest, m_wdest;
    {m_av, m_bv, m_wv, m_a, m_b, m_o1, m_o2, m_off, m_pc, m_opc, m_kind, m_pred, m_cond} = '0;
    {m_arob, m_adest, m_brob, m_bdest, m_wdest} = '0;
    @(negedge clk); resetn = 1'b0; in_valid_i = 0; flush_i = 0;
    @(negedge clk); resetn = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid_i = $urandom_range(0, 3) != 0;
      flush_i = $urandom_range(0, 15) == 0;
      alu_ready_i = $urandom_range(0, 3) != 0;
      bnch_ready_i = $urandom_range(0, 3) != 0;
      in_type_i = $urandom_range(0, 7) == 7 ? 5'($urandom) : types[$urandom_range(0, 6)];
      in_rs1_i = 6'($urandom_range(0, 7)); in_rs2_i = 6'($urandom_range(0, 7));
      in_dest_i = 6'($urandom_range(0, 7)); in_rob_i = 6'($urandom);
      in_opcode_i = 4'($urandom); in_pred_i = 4'($urandom); in_imm_vld_i = 1'($urandom);
      in_imm_i = $urandom; in_pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom;
      byp_valid_i = 2'($urandom);
      for (int p = 0; p < 2; p++) begin bd[p] = 6'($urandom_range(0, 7)); bdat[p] = $urandom; end
      #1;
      exp_rdy = (!m_av || alu_ready_i) && (!m_bv || bnch_ready_i);
      n_tests++;
      if ({in_ready_o, rs1_o, rs2_o} !== {exp_rdy, in_rs1_i, in_rs2_i}) begin
        n_fail++; $display("FAIL rnd_ready c%0d got %b/%0d/%0d want %b/%0d/%0d", c, in_ready_o, rs1_o, rs2_o, exp_rdy, in_rs1_i, in_rs2_i);
      end
      acc = in_valid_i && exp_rdy && !flush_i;
      if (m_av && alu_ready_i) m_av = 0;
      if (m_bv && bnch_ready_i) m_bv = 0;
      m_wv = acc && in_type_i != 0 && in_dest_i != 0;
      if (m_wv) m_wdest = in_dest_i;
      if (acc && in_type_i[0]) begin
        m_av = 1; m_a = ref_op(in_rs1_i, rs1_data_i);
        m_b = in_imm_vld_i ? in_imm_i : ref_op(in_rs2_i, rs2_data_i);
        m_opc = in_opcode_i; m_arob = in_rob_i; m_adest = in_dest_i;
      end
      if (acc && (in_type_i[4:1] != 0 || !in_type_i[0])) begin
        m_bv = 1; m_o1 = ref_op(in_rs1_i, rs1_data_i); m_o2 = ref_op(in_rs2_i, rs2_data_i);
        m_off = in_imm_i; m_pc = in_pc_i; m_kind = in_type_i[4:1]; m_cond = in_opcode_i[2:0];
        m_brob = in_rob_i; m_bdest = in_dest_i; m_pred = in_pred_i;
      end
      if (flush_i) begin m_av = 0; m_bv = 0; end
      @(posedge clk); #1;
      n_tests++;
      if ({alu_valid_o, alu_a_o, alu_b_o, alu_opc_o, alu_rob_o, alu_dest_o} !== {m_av, m_a, m_b, m_opc, m_arob, m_adest}) begin
        n_fail++; $display("FAIL rnd_alu c%0d got %h want %h", c, {alu_valid_o, alu_a_o, alu_b_o, alu_opc_o, alu_rob_o, alu_dest_o}, {m_av, m_a, m_b, m_opc, m_arob, m_adest});
      end
      n_tests++;
      if ({bnch_valid_o, bnch_op1_o, bnch_op2_o, bnch_offset_o, bnch_pc_o, bnch_kind_o, bnch_cond_o, bnch_rob_o, bnch_dest_o, bnch_pred_o}
          !== {m_bv, m_o1, m_o2, m_off, m_pc, m_kind, m_cond, m_brob, m_bdest, m_pred}) begin
        n_fail++; $display("FAIL rnd_bnch c%0d got %h want %h", c,
          {bnch_valid_o, bnch_op1_o, bnch_op2_o, bnch_offset_o, bnch_pc_o, bnch_kind_o, bnch_cond_o, bnch_rob_o, bnch_dest_o, bnch_pred_o},
          {m_bv, m_o1, m_o2, m_off, m_pc, m_kind, m_cond, m_brob, m_bdest, m_pred});
      end
      n_tests++;
      if ({wakeup_valid_o, wakeup_valid_o ? wakeup_dest_o : 6'd0} !== {m_wv, m_wv ? m_wdest : 6'd0}) begin
        n_fail++; $display("FAIL rnd_wakeup c%0d got %b/%0d want %b/%0d", c, wakeup_valid_o, wakeup_dest_o, m_wv, m_wdest);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_bypass();
    test_jal_stall();
    test_cond_branch();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
